// File: rtl/mmio_rd_pkg.sv
// Shared constants and request bundle for the MMIO read tracker.
// Holds AFU header addresses, error read data and the {addr, tid} entry.
package mmio_rd_pkg;

    localparam logic [15:0] DFH_ADDR      = 16'h0000;
    localparam logic [15:0] AFU_ID_L_ADDR = 16'h0002;
    localparam logic [15:0] AFU_ID_H_ADDR = 16'h0004;

    localparam logic [63:0] MMIO_RD_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int MMIO_ADDR_W = 16;
    localparam int MMIO_TID_W  = 9;

    typedef struct packed {
        logic [MMIO_ADDR_W-1:0] addr;
        logic [MMIO_TID_W-1:0]  tid;
    } t_mmio_rd_req;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with sync active-low reset.
// Ports: clk, rst, i_push/i_din, i_pop, o_dout (head), o_empty, o_count.
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    // Pointer MSB differs only when the write side has lapped the read side.
    assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty = (r_wr == r_rd);
    assign o_count = r_wr - r_rd;
    assign o_dout  = r_mem[r_rd[AW-1:0]];

    assign w_push = i_push && !w_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_rd_tracker.sv
// CCI-P MMIO read tracker: buffers host reads, issues them to a user
// register file (valid/ready) and returns in-order data on Tx c2.
// Ports: clk, rst (sync, active-low); Rx c0 mmio_rd_valid/addr/tid;
//   req_valid/req_addr/req_ready to user; rsp_valid/rsp_data from user;
//   c2_valid/c2_tid/c2_data to host; overflow (sticky), outstanding.
// Optional: define MMIO_RD_TIMEOUT_EN to force an all-ones response when
//   the oldest issued read waits TIMEOUT cycles without user data.
module mmio_rd_tracker
    import mmio_rd_pkg::*;
#(
    parameter  int DEPTH   = 64,
    parameter  int ADDR_W  = MMIO_ADDR_W,
    parameter  int TID_W   = MMIO_TID_W,
    parameter  int TIMEOUT = 512,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mmio_rd_valid,
    input  logic [ADDR_W-1:0] mmio_rd_addr,
    input  logic [TID_W-1:0]  mmio_rd_tid,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [63:0]       rsp_data,
    output logic              c2_valid,
    output logic [TID_W-1:0]  c2_tid,
    output logic [63:0]       c2_data,
    output logic              overflow,
    output logic [CW-1:0]     outstanding
);

    localparam int RW = $bits(t_mmio_rd_req);

    t_mmio_rd_req     w_req_in;
    t_mmio_rd_req     w_req_head;
    logic             w_req_empty;
    logic [CW-1:0]    w_req_cnt;
    logic [TID_W-1:0] w_tid_head;
    logic             w_tid_empty;
    logic [CW-1:0]    w_tid_cnt;

    logic             w_full;
    logic             w_push;
    logic             w_issue;
    logic             w_take;
    logic             w_force;
    logic             w_rsp_hit;
    logic             w_bypass;
    logic             w_tid_push;
    logic             w_tid_pop;
    logic [TID_W-1:0] w_rsp_tid;

    assign w_req_in.addr = MMIO_ADDR_W'(mmio_rd_addr);
    assign w_req_in.tid  = MMIO_TID_W'(mmio_rd_tid);

    assign outstanding = w_req_cnt + w_tid_cnt;
    assign w_full      = (outstanding == CW'(DEPTH));
    assign w_push      = mmio_rd_valid && !w_full;

    assign req_valid = !w_req_empty;
    assign req_addr  = ADDR_W'(w_req_head.addr);
    assign w_issue   = req_valid && req_ready;

    // A response landing in the same cycle its request issues belongs to
    // that request; its tid skips the tid FIFO entirely.
    assign w_rsp_hit  = w_take && (!w_tid_empty || w_issue);
    assign w_bypass   = w_rsp_hit && w_tid_empty;
    assign w_tid_push = w_issue && !w_bypass;
    assign w_tid_pop  = (w_rsp_hit && !w_tid_empty) || w_force;
    assign w_rsp_tid  = w_tid_empty ? TID_W'(w_req_head.tid)
                                    : w_tid_head;

    sync_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_req_in),
        .i_pop   (w_issue),
        .o_dout  (w_req_head),
        .o_empty (w_req_empty),
        .o_count (w_req_cnt)
    );

    sync_fifo #(
        .W     (TID_W),
        .DEPTH (DEPTH)
    ) u_tid_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tid_push),
        .i_din   (TID_W'(w_req_head.tid)),
        .i_pop   (w_tid_pop),
        .o_dout  (w_tid_head),
        .o_empty (w_tid_empty),
        .o_count (w_tid_cnt)
    );

`ifdef MMIO_RD_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);

    logic [AGE_W-1:0] r_age;
    logic [CW-1:0]    r_skip;
    logic             w_drop;

    // Responses owed to already-forced tids are swallowed, not paired.
    assign w_take  = rsp_valid && (r_skip == '0);
    assign w_drop  = rsp_valid && (r_skip != '0);
    assign w_force = !rsp_valid && !w_tid_empty &&
                     (r_age == AGE_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_age  <= '0;
            r_skip <= '0;
        end else begin
            if (w_tid_empty || w_tid_pop) begin
                r_age <= '0;
            end else if (r_age != AGE_W'(TIMEOUT)) begin
                r_age <= r_age + AGE_W'(1);
            end
            if (w_force) begin
                r_skip <= r_skip + CW'(1);
            end else if (w_drop) begin
                r_skip <= r_skip - CW'(1);
            end
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT;
    assign w_take           = rsp_valid;
    assign w_force          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            c2_valid <= 1'b0;
            c2_tid   <= '0;
            c2_data  <= '0;
            overflow <= 1'b0;
        end else begin
            c2_valid <= w_rsp_hit || w_force;
            if (w_rsp_hit) begin
                c2_tid  <= w_rsp_tid;
                c2_data <= rsp_data;
            end else if (w_force) begin
                c2_tid  <= w_tid_head;
                c2_data <= MMIO_RD_ERR_DATA;
            end
            if (mmio_rd_valid && w_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_rd_tracker.sv
// Directed-vector bench for mmio_rd_tracker.
// Covers reset, latency, ordering, overflow, wrap and mid-run reset.
module tb_mmio_rd_tracker;
    import mmio_rd_pkg::*;

`ifdef MMIO_RD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 512;
`endif

    logic        clk;
    logic        rst;
    logic        mmio_rd_valid;
    logic [15:0] mmio_rd_addr;
    logic [8:0]  mmio_rd_tid;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        c2_valid;
    logic [8:0]  c2_tid;
    logic [63:0] c2_data;
    logic        overflow;
    logic [6:0]  outstanding;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] q_iss [$];
    logic [8:0]  q_tid [$];
    logic [63:0] q_dat [$];

    mmio_rd_tracker #(
        .DEPTH   (64),
        .ADDR_W  (16),
        .TID_W   (9),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_rd_addr  (mmio_rd_addr),
        .mmio_rd_tid   (mmio_rd_tid),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .c2_valid      (c2_valid),
        .c2_tid        (c2_tid),
        .c2_data       (c2_data),
        .overflow      (overflow),
        .outstanding   (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && req_valid && req_ready) q_iss.push_back(req_addr);
        if (c2_valid) begin
            q_tid.push_back(c2_tid);
            q_dat.push_back(c2_data);
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        q_iss.delete();
        q_tid.delete();
        q_dat.delete();
    endtask

    task automatic push(input logic [15:0] a, input logic [8:0] t);
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = a;
        mmio_rd_tid   = t;
        tick();
        mmio_rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        mmio_rd_valid = 1'b0;
        mmio_rd_addr = '0;
        mmio_rd_tid = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        repeat (3) tick();
        chk("rst_c2v", c2_valid, 0);
        chk("rst_reqv", req_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_c2d", c2_data, 0);
        rst = 1'b1;
        tick();

        // single read, user answers two cycles after issue
        req_ready = 1'b1;
        push(16'h0020, 9'h05);
        chk("s_reqv", req_valid, 1);
        chk("s_addr", req_addr, 16'h0020);
        chk("s_out", outstanding, 1);
        tick();
        chk("s_issued", req_valid, 0);
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 64'hDEAD_BEEF;
        chk("s_c2_early", c2_valid, 0);
        tick();
        rsp_valid = 1'b0;
        chk("s_c2v", c2_valid, 1);
        chk("s_c2tid", c2_tid, 9'h05);
        chk("s_c2dat", c2_data, 64'hDEAD_BEEF);
        tick();
        chk("s_pulse", c2_valid, 0);
        chk("s_out0", outstanding, 0);

        // best case: zero-latency user, c2 two cycles after the read
        push(DFH_ADDR, 9'h06);
        chk("b_reqv", req_valid, 1);
        rsp_valid = 1'b1;
        rsp_data  = 64'h55;
        tick();
        rsp_valid = 1'b0;
        chk("b_c2v", c2_valid, 1);
        chk("b_c2tid", c2_tid, 9'h06);
        chk("b_c2dat", c2_data, 64'h55);

        // 8 back-to-back reads held off by req_ready
        req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mmio_rd_valid = 1'b1;
            mmio_rd_addr  = 16'h0100 + 16'(i);
            mmio_rd_tid   = 9'(i);
            tick();
        end
        mmio_rd_valid = 1'b0;
        repeat (20) tick();
        chk("b8_peak", outstanding, 8);
        chk("b8_head", req_addr, 16'h0100);
        clr_q();
        req_ready = 1'b1;
        repeat (8) tick();
        req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = 64'hA0 + 64'(i);
            tick();
        end
        rsp_valid = 1'b0;
        repeat (2) tick();
        chk("b8_niss", q_iss.size(), 8);
        chk("b8_nc2", q_tid.size(), 8);
        for (int i = 0; i < 8 && i < q_iss.size() &&
             i < q_tid.size(); i++) begin
            chk("b8_addr", q_iss[i], 16'h0100 + 16'(i));
            chk("b8_tid", q_tid[i], 9'(i));
            chk("b8_dat", q_dat[i], 64'hA0 + 64'(i));
        end
        chk("b8_out0", outstanding, 0);

        // fill to DEPTH, then one more read overflows
        clr_q();
        for (int i = 0; i < 64; i++) begin
            mmio_rd_valid = 1'b1;
            mmio_rd_addr  = 16'(i);
            mmio_rd_tid   = 9'(i);
            tick();
        end
        chk("f_out64", outstanding, 64);
        chk("f_noovf", overflow, 0);
        mmio_rd_addr = 16'hFFFF;
        mmio_rd_tid  = 9'h1FF;
        tick();
        mmio_rd_valid = 1'b0;
        chk("f_ovf", overflow, 1);
        chk("f_out", outstanding, 64);
        req_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = 64'hC000 + 64'(i);
            tick();
        end
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        repeat (2) tick();
        chk("f_niss", q_iss.size(), 64);
        chk("f_nc2", q_tid.size(), 64);
        for (int i = 0; i < 64 && i < q_iss.size() &&
             i < q_tid.size(); i++) begin
            chk("f_addr", q_iss[i], 16'(i));
            chk("f_tid", q_tid[i], 9'(i));
            chk("f_dat", q_dat[i], 64'hC000 + 64'(i));
        end
        chk("f_out0", outstanding, 0);
        chk("f_sticky", overflow, 1);
        do_reset();
        chk("f_ovfclr", overflow, 0);

        // push and pop in the same cycle at DEPTH-1
        clr_q();
        for (int i = 0; i < 63; i++) push(16'(i), 9'(i));
        chk("pp_out63", outstanding, 63);
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = 16'h003F;
        mmio_rd_tid   = 9'h03F;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 64'h0;
        tick();
        mmio_rd_valid = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        chk("pp_out", outstanding, 63);
        chk("pp_ovf", overflow, 0);
        push(16'h0040, 9'h040);
        chk("pp_out64", outstanding, 64);
        chk("pp_ovf64", overflow, 0);
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        repeat (64) tick();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        tick();
        chk("pp_drain", outstanding, 0);
        chk("pp_nc2", q_tid.size(), 65);

        // 200 sequential reads across many pointer wraps
        req_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            a = 16'(i * 257 + 3);
            push(a, 9'(i));
            rsp_valid = 1'b1;
            rsp_data  = {48'h0, a};
            tick();
            rsp_valid = 1'b0;
            chk("w_dat", c2_data, {48'h0, a});
            chk("w_tid", c2_tid, 9'(i));
        end
        req_ready = 1'b0;
        chk("w_out0", outstanding, 0);

        // reset with 5 reads pending discards them
        for (int i = 0; i < 5; i++) push(AFU_ID_L_ADDR, 9'(i));
        chk("r_out5", outstanding, 5);
        clr_q();
        do_reset();
        chk("r_reqv", req_valid, 0);
        chk("r_out", outstanding, 0);
        chk("r_c2v", c2_valid, 0);
        chk("r_ovf", overflow, 0);
        rsp_valid = 1'b1;
        rsp_data  = 64'h1;
        tick();
        rsp_valid = 1'b0;
        chk("r_empty", c2_valid, 0);
        push(AFU_ID_H_ADDR, 9'h1A);
        chk("r_addr", req_addr, AFU_ID_H_ADDR);
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 64'hABCD;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        chk("r_c2v2", c2_valid, 1);
        chk("r_tid", c2_tid, 9'h1A);
        chk("r_dat", c2_data, 64'hABCD);
        tick();
        chk("r_nc2", q_tid.size(), 1);

`ifdef MMIO_RD_TIMEOUT_EN
        // user never answers tid 3: forced all-ones response
        begin
            bit seen;
            seen = 1'b0;
            req_ready = 1'b1;
            push(16'h0030, 9'h003);
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                if (c2_valid) seen = 1'b1;
            end
            chk("t_seen", seen, 1);
            chk("t_tid", c2_tid, 9'h003);
            chk("t_dat", c2_data, MMIO_RD_ERR_DATA);
            tick();
            rsp_valid = 1'b1;
            rsp_data  = 64'h777;
            tick();
            rsp_valid = 1'b0;
            chk("t_swallow", c2_valid, 0);
            tick();
            chk("t_quiet", c2_valid, 0);
            push(16'h0034, 9'h004);
            rsp_valid = 1'b1;
            rsp_data  = 64'h1234;
            tick();
            rsp_valid = 1'b0;
            req_ready = 1'b0;
            chk("t_c2v", c2_valid, 1);
            chk("t_tid2", c2_tid, 9'h004);
            chk("t_dat2", c2_data, 64'h1234);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
